// File: rtl/axis_rr_arbiter.sv
// Round-robin packet arbiter for AXI-Stream style requesters.
// A grant is held for a whole packet (until the granted beat with last=1),
// then one ARB cycle re-arbitrates starting after the previous winner.
// Accepted beats go through a 2-entry skid buffer, so in_ready depends only
// on registered state and the output side sees registered data.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 4,
  parameter int SRC_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [SRC_WIDTH-1:0]             out_src,
  output logic                             out_valid,
  input  logic                             out_ready
);

  typedef enum logic {ARB, LOCKED} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [SRC_WIDTH-1:0]  src;
  } beat_t;

  state_t               state_q, state_d;
  logic [SRC_WIDTH-1:0] g_q, g_d;
  logic [SRC_WIDTH-1:0] rr_q, rr_d;
  logic [SRC_WIDTH-1:0] rr_nxt;
  logic [SRC_WIDTH-1:0] pick_idx;
  logic                 pick_vld;

  beat_t                mem [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count;
  logic                 buf_full;
  logic                 accept;
  logic                 pop;
  beat_t                head;

  assign buf_full = (count == 2'd2);
  assign accept   = (state_q == LOCKED) && in_valid[g_q] && !buf_full;
  assign pop      = out_valid && out_ready;

  // Round-robin pick: first valid index at or after rr_q, wrapping.
  // Scanned from the far end so the closest index to rr_q wins last.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_INPUTS;
      if (in_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx[SRC_WIDTH-1:0];
      end
    end
  end

  // Pointer for the next arbitration: one past the current grant, wrapping.
  always_comb begin
    if (int'(g_q) == NUM_INPUTS - 1) rr_nxt = '0;
    else                             rr_nxt = g_q + 1'b1;
  end

  // Grant FSM next-state: ARB picks a winner, LOCKED releases on the last beat.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    case (state_q)
      ARB: begin
        if (pick_vld) begin
          state_d = LOCKED;
          g_d     = pick_idx;
        end
      end
      LOCKED: begin
        if (accept && in_last[g_q]) begin
          state_d = ARB;
          rr_d    = rr_nxt;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Grant FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      g_q     <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
    end
  end

  // Only the granted requester may push, and only while the buffer has room.
  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED && !buf_full) in_ready[g_q] = 1'b1;
  end

  // Skid buffer pointers and occupancy; a simultaneous push and pop cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Skid buffer storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr].data <= in_data[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
      mem[wr_ptr].last <= in_last[g_q];
      mem[wr_ptr].src  <= g_q;
    end
  end

  // Output is the buffer head, forced to zero while empty.
  assign head      = mem[rd_ptr];
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid ? head.last : 1'b0;
  assign out_src   = out_valid ? head.src  : '0;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-requester beat queues feed the DUT, every
// accepted beat is pushed to a scoreboard, and each output handshake pops
// and compares against it. Scenario tasks add arbitration-order checks.
module tb_axis_rr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last, in_valid, in_ready;
  logic [DW-1:0]   out_data;
  logic            out_last, out_valid, out_ready;
  logic [SW-1:0]   out_src;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SRC_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         rq [N][$];
  beat_t         sb [$];
  int            src_trace [$];
  int            acc_cyc [$];
  logic [N-1:0]  mask;
  logic [3:0]    ready_pat;
  int            cyc;
  int            occ;
  int            errors;
  int            checks;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [SW-1:0] prev_src;

  task automatic load(input int src, input int first, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.src  = SW'(src);
      b.data = DW'(first + k);
      b.last = (k == len - 1);
      rq[src].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (mask[i] && rq[i].size() > 0) begin
        in_valid[i]         = 1'b1;
        in_data[i*DW +: DW] = rq[i][0].data;
        in_last[i]          = rq[i][0].last;
      end else begin
        in_valid[i]         = 1'b0;
        in_data[i*DW +: DW] = DW'($urandom);
        in_last[i]          = 1'($urandom);
      end
    end
    out_ready = ready_pat[cyc % 4];
  endtask

  // One clock: observe handshakes at the negedge, step the edge, redrive.
  task automatic tick();
    beat_t e;
    beat_t b;
    checks++;
    if ($countones(in_ready) > 1) begin
      errors++; $display("FAIL in_ready_onehot: got %b want at most one bit", in_ready);
    end
    if (occ == 2) begin
      checks++;
      if (in_ready !== '0) begin
        errors++; $display("FAIL in_ready_when_full: got %b want 0000", in_ready);
      end
    end
    if (prev_stall) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last || out_src !== prev_src) begin
        errors++;
        $display("FAIL out_stable: got v=%b d=%h l=%b s=%0d want v=1 d=%h l=%b s=%0d",
                 out_valid, out_data, out_last, out_src, prev_data, prev_last, prev_src);
      end
    end
    if (!reset) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL out_unexpected: got d=%h s=%0d want no beat", out_data, out_src);
        end else begin
          e = sb.pop_front();
          if (out_src !== e.src || out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL out_beat: got s=%0d d=%h l=%b want s=%0d d=%h l=%b",
                     out_src, out_data, out_last, e.src, e.data, e.last);
          end
        end
        src_trace.push_back(int'(out_src));
        occ--;
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          b = rq[i].pop_front();
          sb.push_back(b);
          acc_cyc.push_back(cyc);
          occ++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_src   = out_src;
    end else begin
      sb.delete();
      occ        = 0;
      prev_stall = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive();
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() + sb.size()) != 0 || out_valid) begin
      if (n >= bound) begin
        checks++; errors++;
        $display("FAIL %s_timeout: got %0d beats pending want 0", name, sb.size());
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) rq[i].delete();
    mask      = '1;
    ready_pat = 4'hF;
    reset     = 1'b1;
    drive();
    tick();
    tick();
    reset = 1'b0;
    drive();
    src_trace.delete();
    acc_cyc.delete();
  endtask

  task automatic check_trace(input string name, input int exp_tr[$]);
    checks++;
    if (src_trace.size() != exp_tr.size()) begin
      errors++; $display("FAIL %s_len: got %0d want %0d", name, src_trace.size(), exp_tr.size());
    end
    for (int k = 0; k < exp_tr.size(); k++) begin
      checks++;
      if (src_trace.size() <= k || src_trace[k] != exp_tr[k]) begin
        errors++;
        $display("FAIL %s[%0d]: got %0d want %0d", name, k,
                 (src_trace.size() > k) ? src_trace[k] : -1, exp_tr[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive();
    tick();
    tick();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_last  !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    if (out_src   !== '0)   begin errors++; $display("FAIL rst_out_src: got %0d want 0", out_src); end
    if (out_data  !== '0)   begin errors++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    if (in_ready  !== '0)   begin errors++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
    reset = 1'b0;
    drive();
  endtask

  task automatic test_round_robin();
    int exp_gap [8] = '{1, 2, 1, 2, 1, 2, 1, 2};
    reset_dut();
    for (int i = 0; i < N; i++) load(i, i * 16, 2);
    load(0, 8'h80, 2);
    drain("rr", 80);
    check_trace("rr_order", '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0});
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (acc_cyc.size() < 9 || acc_cyc[k+1] - acc_cyc[k] != exp_gap[k]) begin
        errors++;
        $display("FAIL rr_gap[%0d]: got %0d want %0d", k,
                 (acc_cyc.size() >= 9) ? acc_cyc[k+1] - acc_cyc[k] : -1, exp_gap[k]);
      end
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    load(2, 8'h20, 1);
    drain("wrap_a", 20);
    load(1, 8'h11, 1);
    drain("wrap_b", 20);
    load(1, 8'h12, 1);
    load(2, 8'h22, 1);
    drain("wrap_c", 20);
    check_trace("wrap_order", '{2, 1, 2, 1});
  endtask

  task automatic test_stall();
    reset_dut();
    ready_pat = 4'b1001;
    load(2, 8'h10, 6);
    drive();
    drain("stall", 80);
    check_trace("stall_order", '{2, 2, 2, 2, 2, 2});
    ready_pat = 4'hF;
  endtask

  task automatic test_hold();
    int n;
    reset_dut();
    load(0, 8'h40, 4);
    load(1, 8'h50, 2);
    drive();
    n = 0;
    while (rq[0].size() == 4 && n < 20) begin tick(); n++; end
    checks++;
    if (rq[0].size() != 3) begin
      errors++; $display("FAIL hold_first_beat: got %0d left want 3", rq[0].size());
    end
    mask[0] = 1'b0;
    drive();
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL hold_no_grant1[%0d]: got %b want 0", k, in_ready[1]); end
      if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL hold_grant0[%0d]: got %b want 1", k, in_ready[0]); end
      tick();
    end
    mask[0] = 1'b1;
    drive();
    drain("hold", 40);
    check_trace("hold_order", '{0, 0, 0, 0, 1, 1});
  endtask

  task automatic test_reset_mid();
    int n;
    reset_dut();
    ready_pat = 4'h0;
    load(3, 8'h30, 5);
    drive();
    n = 0;
    while (occ < 2 && n < 20) begin tick(); n++; end
    checks++;
    if (occ != 2) begin errors++; $display("FAIL mid_fill: got occ %0d want 2", occ); end
    rq[3].delete();
    reset = 1'b1;
    drive();
    tick();
    reset = 1'b0;
    ready_pat = 4'hF;
    drive();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    if (in_ready  !== '0)   begin errors++; $display("FAIL mid_in_ready: got %b want 0000", in_ready); end
    src_trace.delete();
    load(3, 8'h3A, 1);
    load(0, 8'h0A, 1);
    drive();
    drain("mid", 20);
    check_trace("mid_order", '{0, 3});
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    occ        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_src   = '0;
    mask       = '1;
    ready_pat  = 4'hF;
    reset      = 1'b1;
    in_data    = '0;
    in_last    = '0;
    in_valid   = '0;
    out_ready  = 1'b1;
    @(negedge clk);
    drive();
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per beat, multiple of 8.
REQ-002 SHALL have parameter NUM_INPUTS, default 4: requester stream count, range 1..16.
REQ-003 SHALL have parameter SRC_WIDTH, default 2: out_src width, at least clog2(NUM_INPUTS), minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_data, input, NUM_INPUTS*DATA_WIDTH bits: requester i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_last, input, NUM_INPUTS bits: per-requester end-of-packet flag.
REQ-008 SHALL have port in_valid, input, NUM_INPUTS bits: per-requester beat valid.
REQ-009 SHALL have port in_ready, output, NUM_INPUTS bits: per-requester beat accept.
REQ-010 SHALL have port out_data, output, DATA_WIDTH bits: arbitrated payload.
REQ-011 SHALL have port out_last, output, 1 bit: end-of-packet flag of the current out beat.
REQ-012 SHALL have port out_src, output, SRC_WIDTH bits: index of the requester that sourced the current out beat.
REQ-013 SHALL have port out_valid, output, 1 bit: out beat valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-015 SHALL define a handshake on any stream as valid && ready in the same cycle.
REQ-016 SHALL implement a two-state FSM:
- ARB: no grant.
- LOCKED: grant register g holds one requester index.
REQ-017 SHALL, in ARB, assert no in_ready bit.
REQ-018 SHALL, in ARB with any in_valid set, pick the first set in_valid index at or after rr_ptr, scanning upward and wrapping modulo NUM_INPUTS.
REQ-019 SHALL, on an ARB pick, load g and enter LOCKED on the next edge; ARB with no in_valid set stays in ARB.
REQ-020 SHALL, in LOCKED, drive in_ready[g] = !buf_full and all other in_ready bits 0.
REQ-021 SHALL derive in_ready only from registered state, with no combinational path from any in_valid or from out_ready.
REQ-022 SHALL hold g through the whole packet, including cycles where in_valid[g] is low; there is no timeout.
REQ-023 SHALL, on a granted handshake with in_last[g]=1:
- enter ARB on the next edge;
- set rr_ptr = (g+1) mod NUM_INPUTS.
REQ-024 SHALL leave exactly one ARB cycle between consecutive packets when requests are continuously pending.
REQ-025 SHALL buffer accepted beats in a 2-entry skid buffer; each entry holds {data, last, src}; buf_full means 2 entries held.
REQ-026 SHALL present a beat accepted at edge t on out_* after that edge when the buffer was empty: 1-cycle latency.
REQ-027 SHALL sustain 1 beat per cycle while out_ready=1.
REQ-028 SHALL never deassert out_valid without an out handshake.
REQ-029 SHALL hold out_data, out_last and out_src stable while out_valid=1 and out_ready=0.
REQ-030 SHALL emit beats in acceptance order, with no loss or duplication.
REQ-031 SHALL never interleave beats of different packets on out.
REQ-032 SHALL, when an accept and an out handshake occur in the same cycle, keep occupancy unchanged.
REQ-033 SHALL wrap rr_ptr from NUM_INPUTS-1 to 0.
REQ-034 SHALL, with NUM_INPUTS=1, always grant index 0 and still insert the ARB cycle.
REQ-035 SHALL treat a 1-beat packet (first beat has last=1) as a full grant/release cycle.
REQ-036 SHALL ignore in_data and in_last of non-granted requesters.

Reset
REQ-037 SHALL, while reset=1 at an edge:
- enter ARB;
- set rr_ptr=0, g=0;
- empty the buffer;
- drive out_valid=0, out_last=0, out_src=0, out_data=0, in_ready=0.
REQ-038 SHALL, on reset mid-packet, discard buffered beats and the partial grant; no beat of that packet appears afterwards.
REQ-039 SHALL give reset priority over every simultaneous handshake.

Verification
REQ-040 SHALL be covered: after reset, in_valid=4'b1111 with 2-beat packets and out_ready=1 -> out_src sequence 0,0,1,1,2,2,3,3,0; 1 ARB cycle between packets.
REQ-041 SHALL be covered: rr_ptr=3 with only requester 1 valid -> grant 1, next rr_ptr=2.
REQ-042 SHALL be covered: requester 2 streams 0x10..0x15 with last on 0x15, out_ready toggling 1,0,0,1 -> out beats 0x10..0x15 in order, stable while stalled, in_ready[2] low whenever buf_full.
REQ-043 SHALL be covered: requester 0 granted, in_valid[0] drops for 3 cycles mid-packet while requester 1 is valid -> requester 1 is not granted until requester 0 sends last.
REQ-044 SHALL be covered: reset asserted with 2 beats buffered and out_ready=0 -> next cycle out_valid=0, in_ready=0, rr_ptr=0.
REQ-045 SHALL be covered: formal checks AXI-Stream stability on out and per-requester data ordering using an arbitrary-index tracker.
